// File: rtl/spi_bus_capture_if.sv
// spi_bus_capture_if: sniffed SPI lines, MITM handshake and capture results
interface spi_bus_capture_if #(parameter int DATA_SIZE = 8);
   logic                 cs_n_in;
   logic                 sclk_in;
   logic                 mosi_in;
   logic                 miso_in;
   logic [DATA_SIZE-1:0] fake_mosi_data;
   logic [DATA_SIZE-1:0] fake_miso_data;
   logic                 fake_mosi_select;
   logic                 fake_miso_select;
   logic                 done_sig;
   logic                 eval;
   logic [DATA_SIZE-1:0] real_mosi_data;
   logic [DATA_SIZE-1:0] real_miso_data;
   logic                 mosi_out;
   logic                 miso_out;
   logic                 frame_active;
   logic                 overrun;

   modport master (
      output cs_n_in, sclk_in, mosi_in, miso_in,
      output fake_mosi_data, fake_miso_data, fake_mosi_select, fake_miso_select, done_sig,
      input  eval, real_mosi_data, real_miso_data, mosi_out, miso_out, frame_active, overrun
   );

   modport slave (
      input  cs_n_in, sclk_in, mosi_in, miso_in,
      input  fake_mosi_data, fake_miso_data, fake_mosi_select, fake_miso_select, done_sig,
      output eval, real_mosi_data, real_miso_data, mosi_out, miso_out, frame_active, overrun
   );
endinterface

// File: rtl/spi_bus_capture.sv
// spi_bus_capture: mode-0 SPI sniffer that captures words and substitutes MITM replacements one word later
module spi_bus_capture #(parameter int DATA_SIZE = 8) (
   input logic              sys_clk,
   input logic              rst_n,
   spi_bus_capture_if.slave bus
);
   localparam int CW = $clog2(DATA_SIZE + 1);

   typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH} state_t;

   state_t               state, state_next;
   logic [2:0]           cs_sync, sclk_sync;
   logic [1:0]           mosi_sync, miso_sync, settle;
   logic                 armed, frame_active, sclk_rise, sclk_fall, cs_rise, word_done, load;
   logic [CW-1:0]        cnt;
   logic [DATA_SIZE-1:0] rx_mosi, rx_miso, mosi_tx, miso_tx, real_mosi, real_miso;
   logic                 sel_mosi, sel_miso, eval, overrun;

   assign sclk_rise    = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall    = ~sclk_sync[1] & sclk_sync[2];
   assign cs_rise      = cs_sync[1] & ~cs_sync[2];
   assign frame_active = armed & ~cs_sync[1];
   assign word_done    = cnt == CW'(DATA_SIZE);

   // two-flop synchronizers, with a third copy of cs_n and sclk for edge detection
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         miso_sync <= '0;
      end else begin
         cs_sync   <= {cs_sync[1:0], bus.cs_n_in};
         sclk_sync <= {sclk_sync[1:0], bus.sclk_in};
         mosi_sync <= {mosi_sync[0], bus.mosi_in};
         miso_sync <= {miso_sync[0], bus.miso_in};
      end

   // arm capture only once a genuine cs_n high has crossed the synchronizer after reset
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         settle <= {settle[0], 1'b1};
         armed  <= armed | (settle[1] & cs_sync[1]);
      end

   // bit counter and receive shifters; a finished word is consumed or discarded on the next cycle
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         cnt     <= '0;
         rx_mosi <= '0;
         rx_miso <= '0;
      end else if (word_done || cs_rise) begin
         cnt     <= '0;
         rx_mosi <= '0;
         rx_miso <= '0;
      end else if (sclk_rise && frame_active) begin
         cnt     <= cnt + 1'b1;
         rx_mosi <= {rx_mosi[DATA_SIZE-2:0], mosi_sync[1]};
         rx_miso <= {rx_miso[DATA_SIZE-2:0], miso_sync[1]};
      end

   // eval pulse and last good words when idle; a word arriving while busy only flags overrun
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         eval      <= 1'b0;
         overrun   <= 1'b0;
         real_mosi <= '0;
         real_miso <= '0;
      end else begin
         eval      <= word_done && state == IDLE;
         real_mosi <= word_done && state == IDLE ? rx_mosi : real_mosi;
         real_miso <= word_done && state == IDLE ? rx_miso : real_miso;
         overrun   <= overrun | (word_done && state != IDLE);
      end

   // FSM state register
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_next;

   // handshake: done_sig must be seen low before its high is trusted as completion
   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE:      if (word_done) state_next = WAIT_LOW;
         WAIT_LOW:  if (!bus.done_sig) state_next = WAIT_HIGH;
         WAIT_HIGH: if (bus.done_sig) begin
            state_next = IDLE;
            load       = 1'b1;
         end
         default:   state_next = IDLE;
      endcase
   end

   // replacement shifters: load on completion, shift on sclk falls, drop substitution when cs_n rises
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         mosi_tx  <= '0;
         miso_tx  <= '0;
         sel_mosi <= 1'b0;
         sel_miso <= 1'b0;
      end else if (load) begin
         mosi_tx  <= bus.fake_mosi_data;
         miso_tx  <= bus.fake_miso_data;
         sel_mosi <= bus.fake_mosi_select;
         sel_miso <= bus.fake_miso_select;
      end else begin
         sel_mosi <= cs_rise ? 1'b0 : sel_mosi;
         sel_miso <= cs_rise ? 1'b0 : sel_miso;
         mosi_tx  <= sclk_fall && frame_active ? {mosi_tx[DATA_SIZE-2:0], 1'b0} : mosi_tx;
         miso_tx  <= sclk_fall && frame_active ? {miso_tx[DATA_SIZE-2:0], 1'b0} : miso_tx;
      end

   assign bus.eval           = eval;
   assign bus.overrun        = overrun;
   assign bus.frame_active   = frame_active;
   assign bus.real_mosi_data = real_mosi;
   assign bus.real_miso_data = real_miso;
   assign bus.mosi_out       = sel_mosi ? mosi_tx[DATA_SIZE-1] : bus.mosi_in;
   assign bus.miso_out       = sel_miso ? miso_tx[DATA_SIZE-1] : bus.miso_in;
endmodule

// File: tb/tb_spi_bus_capture.sv
// tb_spi_bus_capture: random and directed SPI frames against a word-level scoreboard
module tb_spi_bus_capture;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          failures = 0;
   logic        mitm_en = 1'b1;
   logic        mitm_echo = 1'b0;
   logic [7:0]  fk_mosi = '0, fk_miso = '0;
   logic        fk_sm = 1'b0, fk_ss = 1'b0;
   logic [15:0] exp_q[$];

   spi_bus_capture_if #(.DATA_SIZE(8)) bus();

   spi_bus_capture #(.DATA_SIZE(8)) dut (.sys_clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // MITM model: done low one cycle after eval, high the next, with fresh replacement words
   initial begin
      bus.done_sig         = 1'b1;
      bus.fake_mosi_data   = '0;
      bus.fake_miso_data   = '0;
      bus.fake_mosi_select = 1'b0;
      bus.fake_miso_select = 1'b0;
      forever begin
         @(negedge clk);
         if (mitm_en && rst_n && bus.eval) begin
            @(posedge clk);
            #1;
            fk_mosi              = 8'($urandom);
            fk_miso              = mitm_echo ? bus.real_mosi_data : 8'($urandom);
            fk_sm                = mitm_echo ? 1'b0 : 1'($urandom);
            fk_ss                = mitm_echo ? 1'b1 : 1'($urandom);
            bus.fake_mosi_data   = fk_mosi;
            bus.fake_miso_data   = fk_miso;
            bus.fake_mosi_select = fk_sm;
            bus.fake_miso_select = fk_ss;
            bus.done_sig         = 1'b0;
            @(posedge clk);
            #1;
            bus.done_sig = 1'b1;
         end
      end
   end

   // scoreboard monitor: every eval pulse must match the oldest expected word pair
   always @(negedge clk)
      if (rst_n && bus.eval) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_eval actual=%h%h required=no eval", bus.real_mosi_data, bus.real_miso_data);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if ({bus.real_mosi_data, bus.real_miso_data} !== e) begin
               failures++;
               $display("FAIL eval_words actual=%h%h required=%h", bus.real_mosi_data, bus.real_miso_data, e);
            end
         end
      end

   // drive nbits of a mode-0 word MSB first, checking the target-side lines before each rising edge
   task automatic send_word(input logic [7:0] m, input logic [7:0] s, input logic sm, input logic ss,
                            input logic [7:0] tm, input logic [7:0] ts, input int nbits, input logic want_eval);
      if (want_eval) exp_q.push_back({m, s});
      for (int i = 7; i > 7 - nbits; i--) begin
         bus.mosi_in = m[i];
         bus.miso_in = s[i];
         tick(6);
         check("mosi_out", 16'(bus.mosi_out), 16'(sm ? tm[i] : m[i]));
         check("miso_out", 16'(bus.miso_out), 16'(ss ? ts[i] : s[i]));
         bus.sclk_in = 1'b1;
         tick(2);
         bus.sclk_in = 1'b0;
      end
      tick(16);
   endtask

   task automatic frame_start();
      bus.cs_n_in = 1'b0;
      tick(6);
   endtask

   task automatic frame_end();
      bus.cs_n_in = 1'b1;
      tick(8);
      check("frame_active_low", 16'(bus.frame_active), 16'd0);
   endtask

   // random frame: first word forwarded, later words carry the previous word's replacements
   task automatic rand_frame();
      int         n;
      logic       sm, ss;
      logic [7:0] tm, ts, m, s;
      n  = $urandom_range(1, 3);
      sm = 1'b0;
      ss = 1'b0;
      tm = '0;
      ts = '0;
      frame_start();
      check("frame_active_high", 16'(bus.frame_active), 16'd1);
      for (int w = 0; w < n; w++) begin
         m = 8'($urandom);
         s = 8'($urandom);
         send_word(m, s, sm, ss, tm, ts, 8, 1'b1);
         sm = fk_sm;
         ss = fk_ss;
         tm = fk_mosi;
         ts = fk_miso;
      end
      frame_end();
   endtask

   initial begin
      logic [7:0] r;
      bus.cs_n_in = 1'b1;
      bus.sclk_in = 1'b0;
      bus.mosi_in = 1'b0;
      bus.miso_in = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(4);
      check("rst_eval", 16'(bus.eval), 16'd0);
      check("rst_overrun", 16'(bus.overrun), 16'd0);
      check("rst_frame_active", 16'(bus.frame_active), 16'd0);
      check("rst_real", {bus.real_mosi_data, bus.real_miso_data}, 16'h0000);
      frame_start();
      send_word(8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b1);
      frame_end();
      mitm_echo = 1'b1;
      frame_start();
      r = 8'($urandom);
      send_word(8'hA5, r, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b1);
      send_word(8'h11, ~r, 1'b0, 1'b1, 8'h00, 8'hA5, 8, 1'b1);
      frame_end();
      mitm_echo = 1'b0;
      repeat (12) rand_frame();
      check("overrun_clear", 16'(bus.overrun), 16'd0);
      frame_start();
      send_word(8'hF3, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00, 5, 1'b0);
      frame_end();
      frame_start();
      send_word(8'h0F, 8'hC3, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b1);
      frame_end();
      mitm_en = 1'b0;
      frame_start();
      send_word(8'h5E, 8'h21, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b1);
      check("stale_no_overrun_yet", 16'(bus.overrun), 16'd0);
      send_word(8'h77, 8'h88, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b0);
      check("stale_overrun", 16'(bus.overrun), 16'd1);
      check("stale_real_kept", {bus.real_mosi_data, bus.real_miso_data}, 16'h5E21);
      frame_end();
      mitm_en = 1'b1;
      frame_start();
      send_word(8'hB6, 8'h4D, 1'b0, 1'b0, 8'h00, 8'h00, 3, 1'b0);
      rst_n = 1'b0;
      bus.mosi_in = 1'b1;
      bus.miso_in = 1'b0;
      tick(2);
      check("mid_rst_eval", 16'(bus.eval), 16'd0);
      check("mid_rst_overrun", 16'(bus.overrun), 16'd0);
      check("mid_rst_frame_active", 16'(bus.frame_active), 16'd0);
      check("mid_rst_real", {bus.real_mosi_data, bus.real_miso_data}, 16'h0000);
      check("mid_rst_lines", {15'd0, bus.mosi_out ^ bus.miso_out}, 16'd1);
      rst_n = 1'b1;
      tick(6);
      check("post_rst_inactive", 16'(bus.frame_active), 16'd0);
      send_word(8'hE1, 8'h1E, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b0);
      check("post_rst_still_inactive", 16'(bus.frame_active), 16'd0);
      frame_end();
      frame_start();
      send_word(8'h96, 8'h69, 1'b0, 1'b0, 8'h00, 8'h00, 8, 1'b1);
      frame_end();
      tick(20);
      check("pending_evals", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
